// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared types and saturation helpers for the MAC stream engine.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package mac_pkg;

    // Engine control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Largest representable accumulator value; callers truncate to acc_w bits
    function automatic logic [63:0] sat_max(input int unsigned acc_w, input logic is_signed);
        if (is_signed) begin
            return (64'd1 << (acc_w - 1)) - 64'd1;
        end
        return (64'd1 << acc_w) - 64'd1;
    endfunction

    // Smallest representable accumulator value; callers truncate to acc_w bits
    function automatic logic [63:0] sat_min(input int unsigned acc_w, input logic is_signed);
        if (is_signed) begin
            return (~64'd0) << (acc_w - 1);
        end
        return 64'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_mult_stage.sv
`default_nettype none
// ============================================================================
// Module      : mac_mult_stage
// Description : Registered signed/unsigned DATA_W x DATA_W multiplier with a
//               one-cycle product-valid flag.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module mac_mult_stage
    import mac_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_signed_mode,
    input  logic                  i_load,
    input  logic [DATA_W-1:0]     i_a,
    input  logic [DATA_W-1:0]     i_b,
    output logic [2*DATA_W-1:0]   o_prod_r,
    output logic                  o_prod_v,
    output logic [2*DATA_W-1:0]   o_last_prod
);

    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_b_ext;
    logic [2*DATA_W-1:0] w_prod;
    logic [2*DATA_W-1:0] r_prod;
    logic                r_prod_v;

    // Extending to full product width first makes the low 2*DATA_W bits of
    // the multiply correct for both two's-complement and unsigned operands.
    assign w_a_ext = {{DATA_W{i_signed_mode & i_a[DATA_W-1]}}, i_a};
    assign w_b_ext = {{DATA_W{i_signed_mode & i_b[DATA_W-1]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Capture the product on each accepted pair; valid lasts one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prod   <= '0;
            r_prod_v <= 1'b0;
        end else begin
            r_prod_v <= i_load;
            if (i_load) begin
                r_prod <= w_prod;
            end
        end
    end

    // The pipeline product doubles as the debug "most recent product"
    assign o_prod_r    = r_prod;
    assign o_prod_v    = r_prod_v;
    assign o_last_prod = r_prod;

endmodule
`default_nettype wire

// File: rtl/mac_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : mac_stream_engine
// Description : Streaming multiply-accumulate engine. Accepts len operand
//               pairs over valid/ready, accumulates products with saturation
//               and presents the sum on a valid/ready result port.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module mac_stream_engine
    import mac_pkg::*;
#(
    parameter  int DATA_W  = 4,
    parameter  int ACC_W   = 12,
    parameter  int MAX_LEN = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [LEN_W-1:0]      len,
    input  logic                  signed_mode,
    input  logic                  abort,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ACC_W-1:0]      out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ovf,
    output logic                  busy,
    output logic [2*DATA_W-1:0]   last_prod
);

    localparam logic [ACC_W-1:0] c_umax    = ACC_W'(sat_max(ACC_W, 1'b0));
    localparam logic [ACC_W-1:0] c_smax    = ACC_W'(sat_max(ACC_W, 1'b1));
    localparam logic [ACC_W-1:0] c_smin    = ACC_W'(sat_min(ACC_W, 1'b1));
    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
    localparam int               c_pad     = ACC_W + 1 - 2 * DATA_W;

    state_t              r_state;
    state_t              w_next;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_count;
    logic [LEN_W-1:0]    w_len_clamp;
    logic                r_signed;
    logic [ACC_W-1:0]    r_acc;
    logic                r_ovf;
    logic                w_start;
    logic                w_load;
    logic                w_last_xfer;
    logic [2*DATA_W-1:0] w_prod;
    logic                w_prod_v;
    logic [ACC_W:0]      w_prod_ext;
    logic [ACC_W:0]      w_acc_ext;
    logic [ACC_W:0]      w_sum;
    logic                w_sum_ovf;
    logic [ACC_W-1:0]    w_sat;

    assign in_ready  = (r_state == RUN);
    assign out_valid = (r_state == HOLD);
    assign busy      = (r_state != IDLE);
    assign out       = r_acc;
    assign ovf       = r_ovf;

    assign w_start     = (r_state == IDLE) && go;
    assign w_len_clamp = (len > c_max_len) ? c_max_len : len;
    // abort outranks a pair offered in the same cycle
    assign w_load      = in_ready && in_valid && !abort;
    assign w_last_xfer = w_load && (LEN_W'(r_count + LEN_W'(1)) == r_len);

    mac_mult_stage #(
        .DATA_W (DATA_W)
    ) u_mult (
        .clk           (clk),
        .rst           (rst),
        .i_signed_mode (r_signed),
        .i_load        (w_load),
        .i_a           (a),
        .i_b           (b),
        .o_prod_r      (w_prod),
        .o_prod_v      (w_prod_v),
        .o_last_prod   (last_prod)
    );

    // One guard bit above the accumulator exposes overflow in either mode
    assign w_prod_ext = {{c_pad{r_signed & w_prod[2*DATA_W-1]}}, w_prod};
    assign w_acc_ext  = {r_signed & r_acc[ACC_W-1], r_acc};
    assign w_sum      = w_acc_ext + w_prod_ext;
    assign w_sum_ovf  = r_signed ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];
    assign w_sat      = r_signed ? (w_sum[ACC_W] ? c_smin : c_smax) : c_umax;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (go) begin
                    w_next = (w_len_clamp == '0) ? HOLD : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (w_last_xfer) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                w_next = abort ? IDLE : HOLD;
            end
            HOLD: begin
                if (abort || out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Run configuration and accepted-pair counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len    <= '0;
            r_signed <= 1'b0;
            r_count  <= '0;
        end else if (w_start) begin
            r_len    <= w_len_clamp;
            r_signed <= signed_mode;
            r_count  <= '0;
        end else if (w_load) begin
            r_count  <= LEN_W'(r_count + LEN_W'(1));
        end
    end

    // Saturating accumulator with sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_start) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_prod_v) begin
            if (w_sum_ovf) begin
                r_acc <= w_sat;
                r_ovf <= 1'b1;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_stream_engine
// Description : Scoreboard bench for mac_stream_engine; drives a default
//               (ACC_W=12) and a narrow (ACC_W=8) instance with identical
//               stimulus and checks both against an integer reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_stream_engine;

    typedef struct packed {
        logic [11:0] val;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        go;
    logic [3:0]  len;
    logic        signed_mode;
    logic        abort;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, ovf_a, busy_a;
    logic [11:0] out_a;
    logic [7:0]  last_prod_a;
    logic        in_ready_b, out_valid_b, ovf_b, busy_b;
    logic [7:0]  out_b;
    logic [7:0]  last_prod_b;

    int   checks = 0;
    int   errors = 0;
    int   pa[16];
    int   pb[16];
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a;
    exp_t e_b;

    mac_stream_engine dut_a (
        .clk(clk), .rst(rst), .go(go), .len(len), .signed_mode(signed_mode),
        .abort(abort), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready_a),
        .out(out_a), .out_valid(out_valid_a), .out_ready(out_ready), .ovf(ovf_a),
        .busy(busy_a), .last_prod(last_prod_a)
    );

    mac_stream_engine #(.ACC_W(8)) dut_b (
        .clk(clk), .rst(rst), .go(go), .len(len), .signed_mode(signed_mode),
        .abort(abort), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready_b),
        .out(out_b), .out_valid(out_valid_b), .out_ready(out_ready), .ovf(ovf_b),
        .busy(busy_b), .last_prod(last_prod_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
        end
    endtask

    function automatic int sval(input int x, input bit sgn);
        return (sgn && x >= 8) ? x - 16 : x;
    endfunction

    // Reference: integer sum of products, clamped after every addition
    task automatic model(input int n, input bit sgn, input int acc_w, output int res, output bit ov);
        int acc, hi, lo;
        hi  = sgn ? (1 << (acc_w - 1)) - 1 : (1 << acc_w) - 1;
        lo  = sgn ? -(1 << (acc_w - 1)) : 0;
        acc = 0;
        ov  = 1'b0;
        for (int i = 0; i < n; i++) begin
            acc += sval(pa[i], sgn) * sval(pb[i], sgn);
            if (acc > hi) begin
                acc = hi;
                ov  = 1'b1;
            end else if (acc < lo) begin
                acc = lo;
                ov  = 1'b1;
            end
        end
        res = acc & ((1 << acc_w) - 1);
    endtask

    task automatic fail_recover(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no DUT response within bound, required a response", name);
        q_a.delete();
        q_b.delete();
        in_valid  = 1'b0;
        go        = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Scoreboard monitors: one pop per accepted result on each instance
    always @(negedge clk) begin
        if (rst && out_valid_a && out_ready) begin
            if (q_a.size() == 0) begin
                chk("unexpected_result_a", {20'd0, out_a}, 32'hFFFF_FFFF);
            end else begin
                e_a = q_a.pop_front();
                chk("out_a", {20'd0, out_a}, {20'd0, e_a.val});
                chk("ovf_a", {31'd0, ovf_a}, {31'd0, e_a.ovf});
            end
        end
    end

    always @(negedge clk) begin
        if (rst && out_valid_b && out_ready) begin
            if (q_b.size() == 0) begin
                chk("unexpected_result_b", {24'd0, out_b}, 32'hFFFF_FFFF);
            end else begin
                e_b = q_b.pop_front();
                chk("out_b", {24'd0, out_b}, {20'd0, e_b.val});
                chk("ovf_b", {31'd0, ovf_b}, {31'd0, e_b.ovf});
            end
        end
    end

    // One complete run: go, feed pairs pa/pb, wait for result, stall, ack
    task automatic do_run(input int n_len, input bit sgn, input int gap, input int stall, input int direct_a);
        int   n_eff, res, k, guard, g;
        bit   ov, rdy;
        exp_t ex;
        logic [11:0] held;
        n_eff = (n_len > 8) ? 8 : n_len;
        model(n_eff, sgn, 12, res, ov);
        ex.val = 12'(res); ex.ovf = ov; q_a.push_back(ex);
        model(n_eff, sgn, 8, res, ov);
        ex.val = 12'(res); ex.ovf = ov; q_b.push_back(ex);

        out_ready   = 1'b0;
        go          = 1'b1;
        len         = 4'(n_len);
        signed_mode = sgn;
        @(posedge clk); #1;
        go = 1'b0;
        for (int i = 0; i < n_eff; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            in_valid = 1'b0;
            repeat (g) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            a = 4'(pa[i]);
            b = 4'(pb[i]);
            guard = 0;
            do begin
                rdy = in_ready_a;
                @(posedge clk); #1;
                guard++;
            end while (!rdy && guard < 20);
            if (!rdy) begin
                fail_recover("accept_timeout");
                return;
            end
        end
        in_valid = 1'b0;
        if (n_eff > 0) chk("in_ready_after_last", {31'd0, in_ready_a}, 32'd0);
        k = 0;
        while (!out_valid_a && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (!out_valid_a) begin
            fail_recover("out_valid_timeout");
            return;
        end
        chk("out_valid_latency", k, (n_eff == 0) ? 0 : 1);
        if (direct_a >= 0) chk("direct_out_a", {20'd0, out_a}, direct_a);
        held = out_a;
        for (int s = 0; s < stall; s++) begin
            go = (s == 1);
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, out_valid_a}, 32'd1);
            chk("hold_stable", {20'd0, out_a}, {20'd0, held});
        end
        go        = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("busy_after_ack", {31'd0, busy_a}, 32'd0);
        chk("valid_after_ack", {31'd0, out_valid_a}, 32'd0);
        chk("out_held_in_idle", {20'd0, out_a}, {20'd0, held});
        if (n_eff > 0)
            chk("last_prod", {24'd0, last_prod_a},
                (sval(pa[n_eff-1], sgn) * sval(pb[n_eff-1], sgn)) & 255);
        chk("scoreboard_drained", q_a.size() + q_b.size(), 0);
    endtask

    task automatic set_pairs4(input int a0, b0, a1, b1, a2, b2, a3, b3);
        pa[0] = a0; pb[0] = b0; pa[1] = a1; pb[1] = b1;
        pa[2] = a2; pb[2] = b2; pa[3] = a3; pb[3] = b3;
    endtask

    initial begin
        rst = 1'b0; go = 1'b0; len = '0; signed_mode = 1'b0; abort = 1'b0;
        a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", {20'd0, out_a}, 32'd0);
        chk("rst_flags", {27'd0, out_valid_a, in_ready_a, busy_a, ovf_a, out_valid_b}, 32'd0);
        chk("rst_last_prod", {24'd0, last_prod_a}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Unsigned back-to-back, 255
        set_pairs4(3, 5, 2, 7, 15, 15, 1, 1);
        do_run(4, 1'b0, 0, 0, 255);
        // Signed (-8,-8),(7,-8) = 8, then with gaps
        set_pairs4(8, 8, 7, 8, 0, 0, 0, 0);
        do_run(2, 1'b1, 0, 0, 8);
        do_run(2, 1'b1, 3, 0, 8);
        // Saturation cases (narrow instance saturates)
        set_pairs4(15, 15, 15, 15, 0, 0, 0, 0);
        do_run(2, 1'b0, 0, 0, 450);
        set_pairs4(8, 7, 8, 7, 8, 7, 0, 0);
        do_run(3, 1'b1, 0, 0, 12'hF58);
        // Long HOLD stall with ignored go pulse
        set_pairs4(4, 9, 11, 2, 6, 6, 0, 0);
        do_run(3, 1'b0, 0, 5, 36 + 22 + 36);
        // Empty run and over-length clamp
        do_run(0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            pa[i] = $urandom_range(0, 15);
            pb[i] = $urandom_range(0, 15);
        end
        do_run(15, 1'b0, 0, 0, -1);

        // Abort after 2 of 4 pairs, abort coinciding with an offered pair
        set_pairs4(3, 3, 4, 4, 5, 5, 6, 6);
        go = 1'b1; len = 4'd4; signed_mode = 1'b0;
        @(posedge clk); #1;
        go = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; a = 4'(pa[i]); b = 4'(pb[i]);
            @(posedge clk); #1;
        end
        abort = 1'b1; a = 4'(pa[2]); b = 4'(pb[2]);
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", {31'd0, busy_a}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready_a}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_valid", {30'd0, out_valid_a, out_valid_b}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a run
        set_pairs4(3, 5, 2, 7, 15, 15, 1, 1);
        go = 1'b1; len = 4'd4; signed_mode = 1'b0;
        @(posedge clk); #1;
        go = 1'b0;
        in_valid = 1'b1; a = 4'd3; b = 4'd5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_flags", {28'd0, busy_a, in_ready_a, out_valid_a, ovf_a}, 32'd0);
        chk("async_rst_out", {20'd0, out_a}, 32'd0);
        chk("async_rst_last_prod", {24'd0, last_prod_a}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_run(4, 1'b0, 0, 0, 255);

        // Randomised runs
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 16; i++) begin
                pa[i] = $urandom_range(0, 15);
                pb[i] = $urandom_range(0, 15);
            end
            do_run($urandom_range(0, 10), 1'($urandom_range(0, 1)), -1, $urandom_range(0, 3), -1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("final_queues_empty", q_a.size() + q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time bound reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
